// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data memory controller.
// Channel FSM state encoding.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } mem_ctrl_state_t;

endpackage

// File: rtl/data_mem_controller.sv
// Arbitrates per-thread LSU load/store requests onto a small set of
// data memory channels, one consumer transaction per channel at a time.
module data_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    mem_ctrl_state_t        state_q [NUM_CHANNELS];
    mem_ctrl_state_t        state_d [NUM_CHANNELS];
    logic [CW-1:0]          idx_q   [NUM_CHANNELS];
    logic [CW-1:0]          idx_d   [NUM_CHANNELS];
    logic                   is_rd_q [NUM_CHANNELS];
    logic                   is_rd_d [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   addr_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   addr_d  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   data_q  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   data_d  [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]                 pick;
    logic [NUM_CONSUMERS-1:0]                claimed_q;
    logic [NUM_CONSUMERS-1:0]                claimed_d;
    logic [NUM_CONSUMERS-1:0]                mask;
    logic [NUM_CONSUMERS-1:0]                release_m;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            claimed_q <= '0;
            rdata_q   <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                idx_q[ch]   <= '0;
                is_rd_q[ch] <= 1'b0;
                addr_q[ch]  <= '0;
                data_q[ch]  <= '0;
            end
        end else begin
            claimed_q <= claimed_d;
            rdata_q   <= rdata_d;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                idx_q[ch]   <= idx_d[ch];
                is_rd_q[ch] <= is_rd_d[ch];
                addr_q[ch]  <= addr_d[ch];
                data_q[ch]  <= data_d[ch];
            end
        end
    end

    // Channels claim in ascending order against a running mask so that
    // no consumer can be taken by two channels in the same cycle.
    always_comb begin
        mask      = claimed_q;
        release_m = '0;
        rdata_d   = rdata_q;
        pick      = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_d[ch] = state_q[ch];
            idx_d[ch]   = idx_q[ch];
            is_rd_d[ch] = is_rd_q[ch];
            addr_d[ch]  = addr_q[ch];
            data_d[ch]  = data_q[ch];
            unique case (state_q[ch])
                IDLE: begin
                    for (int c = 0; c < NUM_CONSUMERS; c++) begin
                        if (!pick[ch] && !mask[c] &&
                            (consumer_read_valid[c] || consumer_write_valid[c])) begin
                            pick[ch]    = 1'b1;
                            mask[c]     = 1'b1;
                            idx_d[ch]   = CW'(c);
                            is_rd_d[ch] = consumer_read_valid[c];
                            addr_d[ch]  = consumer_read_valid[c] ?
                                          consumer_read_address[c] :
                                          consumer_write_address[c];
                            data_d[ch]  = consumer_write_data[c];
                        end
                    end
                    if (pick[ch])
                        state_d[ch] = is_rd_d[ch] ? READ_WAIT : WRITE_WAIT;
                end
                READ_WAIT: begin
                    if (mem_read_ready[ch]) begin
                        state_d[ch]          = RELAY;
                        rdata_d[idx_q[ch]]   = mem_read_data[ch];
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready[ch])
                        state_d[ch] = RELAY;
                end
                RELAY: begin
                    if (is_rd_q[ch] ? !consumer_read_valid[idx_q[ch]]
                                    : !consumer_write_valid[idx_q[ch]]) begin
                        state_d[ch]          = IDLE;
                        release_m[idx_q[ch]] = 1'b1;
                    end
                end
            endcase
        end
        claimed_d = mask & ~release_m;
    end

    always_comb begin
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        consumer_read_data   = rdata_q;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            mem_read_valid[ch]    = (state_q[ch] == READ_WAIT);
            mem_write_valid[ch]   = (state_q[ch] == WRITE_WAIT);
            mem_read_address[ch]  = addr_q[ch];
            mem_write_address[ch] = addr_q[ch];
            mem_write_data[ch]    = data_q[ch];
            if (state_q[ch] == RELAY) begin
                if (is_rd_q[ch])
                    consumer_read_ready[idx_q[ch]] = 1'b1;
                else
                    consumer_write_ready[idx_q[ch]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: directed vectors, corner
// sequences, a single-channel instance and randomized traffic vs a model.
module tb_data_mem_controller;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 4;
    localparam int NCH = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]          c_rv, c_rr, c_wv, c_wr;
    logic [NC-1:0][AB-1:0]  c_ra, c_wa;
    logic [NC-1:0][DB-1:0]  c_rdata, c_wd;
    logic [NCH-1:0]         m_rv, m_rr, m_wv, m_wr;
    logic [NCH-1:0][AB-1:0] m_ra, m_wa;
    logic [NCH-1:0][DB-1:0] m_rdata, m_wd;

    logic [NC-1:0]          c1_rv, c1_rr, c1_wv, c1_wr;
    logic [NC-1:0][AB-1:0]  c1_ra, c1_wa;
    logic [NC-1:0][DB-1:0]  c1_rdata, c1_wd;
    logic [0:0]             m1_rv, m1_rr, m1_wv, m1_wr;
    logic [0:0][AB-1:0]     m1_ra, m1_wa;
    logic [0:0][DB-1:0]     m1_rdata, m1_wd;

    data_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB),
                          .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rdata),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(m_rv), .mem_read_address(m_ra),
        .mem_read_ready(m_rr), .mem_read_data(m_rdata),
        .mem_write_valid(m_wv), .mem_write_address(m_wa),
        .mem_write_data(m_wd), .mem_write_ready(m_wr)
    );

    data_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB),
                          .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c1_rv), .consumer_read_address(c1_ra),
        .consumer_read_ready(c1_rr), .consumer_read_data(c1_rdata),
        .consumer_write_valid(c1_wv), .consumer_write_address(c1_wa),
        .consumer_write_data(c1_wd), .consumer_write_ready(c1_wr),
        .mem_read_valid(m1_rv), .mem_read_address(m1_ra),
        .mem_read_ready(m1_rr), .mem_read_data(m1_rdata),
        .mem_write_valid(m1_wv), .mem_write_address(m1_wa),
        .mem_write_data(m1_wd), .mem_write_ready(m1_wr)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DB-1:0] mem     [256];
    logic [DB-1:0] ref_mem [256];
    int  mw   [NCH] = '{default: 0};
    int  mcnt [NCH] = '{default: 0};
    bit  rand_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // External memory: ready after mw[ch] wait cycles; noisy ready when idle
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            m_rr[ch] = 1'b0;
            m_wr[ch] = 1'b0;
            if (m_rv[ch] || m_wv[ch]) begin
                if (mcnt[ch] == 0 && rand_mode) mw[ch] = $urandom_range(0, 3);
                if (mcnt[ch] >= mw[ch]) begin
                    if (m_rv[ch]) begin
                        m_rr[ch]    = 1'b1;
                        m_rdata[ch] = mem[m_ra[ch]];
                    end else begin
                        m_wr[ch]     = 1'b1;
                        mem[m_wa[ch]] = m_wd[ch];
                    end
                end
                if (rand_mode) begin
                    if (m_rv[ch]) m_wr[ch] = 1'($urandom);
                    else          m_rr[ch] = 1'($urandom);
                end
                mcnt[ch]++;
            end else begin
                mcnt[ch] = 0;
                if (rand_mode) begin
                    m_rr[ch]    = 1'($urandom);
                    m_wr[ch]    = 1'($urandom);
                    m_rdata[ch] = 8'($urandom);
                end
            end
        end
    end

    always @(negedge clk) begin
        m1_rr       = m1_rv;
        m1_wr       = m1_wv;
        m1_rdata[0] = m1_ra[0] ^ 8'h5A;
    end

    // Consumer c owns addresses with addr[7:6]==c in random traffic
    always @(negedge clk) begin
        if (rand_mode) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (m_rv[ch])
                    chk("inv_rd_owner", {31'd0, c_rv[m_ra[ch][7:6]] &&
                        c_ra[m_ra[ch][7:6]] == m_ra[ch]}, 1);
                if (m_wv[ch])
                    chk("inv_wr_owner", {31'd0, c_wv[m_wa[ch][7:6]] &&
                        c_wa[m_wa[ch][7:6]] == m_wa[ch]}, 1);
            end
            if ((m_rv[0] || m_wv[0]) && (m_rv[1] || m_wv[1]))
                chk("inv_distinct", {31'd0,
                    (m_rv[0] ? m_ra[0][7:6] : m_wa[0][7:6]) !=
                    (m_rv[1] ? m_ra[1][7:6] : m_wa[1][7:6])}, 1);
        end
    end

    typedef struct {
        int          c;
        bit          wr;
        logic [7:0]  a;
        logic [7:0]  d;
        int          w;
        bit          pre;
        int          exp_ch;
        int          exp_lat;
    } vec_t;

    task automatic do_txn(input int c, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input int ch, input int w,
                          input int exp_lat);
        int t, lat, vcnt, first;
        mw[ch] = w;
        @(negedge clk);
        if (wr) begin
            c_wa[c] = a; c_wd[c] = d; c_wv[c] = 1'b1;
        end else begin
            c_ra[c] = a; c_rv[c] = 1'b1;
        end
        t = cyc; lat = -1; vcnt = 0; first = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (wr ? m_wv[ch] : m_rv[ch]) begin
                if (first < 0) begin
                    first = cyc - t;
                    chk("mem_addr", {24'd0, wr ? m_wa[ch] : m_ra[ch]}, {24'd0, a});
                    if (wr) chk("mem_wdata", {24'd0, m_wd[ch]}, {24'd0, d});
                end
                vcnt++;
            end
            if (wr ? c_wr[c] : c_rr[c]) lat = cyc - t;
        end
        chk("issue_lat", first, 1);
        chk("mem_valid_cycles", vcnt, w + 1);
        chk("ready_lat", lat, exp_lat);
        if (wr) chk("mem_written", {24'd0, mem[a]}, {24'd0, d});
        else    chk("rdata", {24'd0, c_rdata[c]}, {24'd0, d});
        if (wr) c_wv[c] = 1'b0; else c_rv[c] = 1'b0;
        @(negedge clk);
        chk("ready_clear", {31'd0, wr ? c_wr[c] : c_rr[c]}, 0);
        if (!wr) chk("rdata_kept", {24'd0, c_rdata[c]}, {24'd0, d});
    endtask

    task automatic wait_ready(input int c, input bit wr);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(wr ? c_wr[c] : c_rr[c]) && k < 200);
        chk(wr ? "rnd_wready" : "rnd_rready", {31'd0, wr ? c_wr[c] : c_rr[c]}, 1);
    endtask

    task automatic cons_proc(input int c);
        for (int n = 0; n < 25; n++) begin
            int op;
            logic [7:0] ra, wa, wd;
            op = $urandom_range(0, 2);
            ra = {c[1:0], 6'($urandom)};
            wa = {c[1:0], 6'($urandom)};
            wd = 8'($urandom);
            @(negedge clk);
            if (op != 1) begin c_ra[c] = ra; c_rv[c] = 1'b1; end
            if (op != 0) begin c_wa[c] = wa; c_wd[c] = wd; c_wv[c] = 1'b1; end
            if (op != 1) begin
                wait_ready(c, 1'b0);
                chk("rnd_rdata", {24'd0, c_rdata[c]}, {24'd0, ref_mem[ra]});
                c_rv[c] = 1'b0;
            end
            if (op != 0) begin
                wait_ready(c, 1'b1);
                ref_mem[wa] = wd;
                c_wv[c] = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int t, nbad;
        int order[$];
        vt[0] = '{1, 1'b0, 8'h12, 8'hA5, 0, 1'b1, 0, 2};
        vt[1] = '{2, 1'b1, 8'h40, 8'h3C, 2, 1'b0, 0, 4};
        vt[2] = '{0, 1'b0, 8'hFF, 8'h5A, 1, 1'b1, 0, 3};
        vt[3] = '{3, 1'b1, 8'h00, 8'hC3, 0, 1'b0, 0, 2};
        vt[4] = '{3, 1'b0, 8'h00, 8'hC3, 3, 1'b0, 0, 5};
        vt[5] = '{2, 1'b0, 8'h40, 8'h3C, 0, 1'b0, 0, 2};

        c_rv = '0; c_wv = '0; c_ra = '0; c_wa = '0; c_wd = '0;
        c1_rv = '0; c1_wv = '0; c1_ra = '0; c1_wa = '0; c1_wd = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 6; i++) if (vt[i].pre) mem[vt[i].a] = vt[i].d;

        repeat (2) @(negedge clk);
        chk("rst_valids", {24'd0, m_rv, m_wv, c_rr}, 0);
        chk("rst_wready", {28'd0, c_wr}, 0);
        chk("rst_addr", {m_ra, m_wa}, 0);
        chk("rst_wdata", {16'd0, m_wd}, 0);
        chk("rst_rdata", c_rdata, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            do_txn(vt[i].c, vt[i].wr, vt[i].a, vt[i].d,
                   vt[i].exp_ch, vt[i].w, vt[i].exp_lat);

        // Consumers 0 and 3 together: channel 0 -> 0, channel 1 -> 3
        mw[0] = 0; mw[1] = 2;
        mem[8'h21] = 8'h11; mem[8'hE3] = 8'h33;
        @(negedge clk);
        c_ra[0] = 8'h21; c_ra[3] = 8'hE3; c_rv = 4'b1001;
        @(negedge clk);
        chk("sim_mrv", {30'd0, m_rv}, 2'b11);
        chk("sim_addr0", {24'd0, m_ra[0]}, 8'h21);
        chk("sim_addr1", {24'd0, m_ra[1]}, 8'hE3);
        @(negedge clk);
        chk("sim_rr_a", {28'd0, c_rr}, 4'b0001);
        chk("sim_data0", {24'd0, c_rdata[0]}, 8'h11);
        c_rv[0] = 1'b0;
        @(negedge clk);
        chk("sim_rr_b", {28'd0, c_rr}, 4'b0000);
        @(negedge clk);
        chk("sim_rr_c", {28'd0, c_rr}, 4'b1000);
        chk("sim_data3", {24'd0, c_rdata[3]}, 8'h33);
        c_rv[3] = 1'b0;
        @(negedge clk);
        chk("sim_rr_d", {28'd0, c_rr}, 4'b0000);

        // Read and write together on consumer 0: read first, then write
        mw[0] = 0; mw[1] = 0;
        mem[8'h05] = 8'h77;
        @(negedge clk);
        c_ra[0] = 8'h05; c_wa[0] = 8'h06; c_wd[0] = 8'h99;
        c_rv[0] = 1'b1; c_wv[0] = 1'b1;
        @(negedge clk);
        chk("rw_mrv", {30'd0, m_rv}, 2'b01);
        chk("rw_mwv_a", {30'd0, m_wv}, 2'b00);
        @(negedge clk);
        chk("rw_rr", {28'd0, c_rr}, 4'b0001);
        chk("rw_wr_a", {28'd0, c_wr}, 4'b0000);
        chk("rw_rdata", {24'd0, c_rdata[0]}, 8'h77);
        c_rv[0] = 1'b0;
        @(negedge clk);
        chk("rw_mwv_b", {30'd0, m_wv}, 2'b00);
        @(negedge clk);
        chk("rw_mwv_c", {30'd0, m_wv}, 2'b01);
        chk("rw_waddr", {24'd0, m_wa[0]}, 8'h06);
        chk("rw_wdata", {24'd0, m_wd[0]}, 8'h99);
        @(negedge clk);
        chk("rw_wr_b", {28'd0, c_wr}, 4'b0001);
        c_wv[0] = 1'b0;
        @(negedge clk);
        chk("rw_wr_c", {28'd0, c_wr}, 4'b0000);
        chk("rw_mem", {24'd0, mem[8'h06]}, 8'h99);

        // Reset while channel 0 waits on memory
        mw[0] = 5;
        mem[8'h30] = 8'h4E;
        @(negedge clk);
        c_ra[1] = 8'h30; c_rv[1] = 1'b1;
        repeat (2) @(negedge clk);
        chk("rr_pre_mrv", {30'd0, m_rv}, 2'b01);
        #2 reset = 1'b0;
        #1;
        chk("rr_valids", {24'd0, m_rv, m_wv, c_rr}, 0);
        chk("rr_wready", {28'd0, c_wr}, 0);
        chk("rr_addr", {m_ra, m_wa}, 0);
        chk("rr_rdata", c_rdata, 0);
        c_rv[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_txn(1, 1'b0, 8'h30, 8'h4E, 0, 0, 2);

        // Single channel: three simultaneous readers served in order
        @(negedge clk);
        c1_ra[0] = 8'h10; c1_ra[1] = 8'h20; c1_ra[2] = 8'h30;
        c1_rv = 4'b0111;
        for (int k = 0; k < 60 && c1_rv != 0; k++) begin
            @(negedge clk);
            chk("one_excl", {31'd0, $countones(c1_rr) <= 1}, 1);
            for (int c = 0; c < NC; c++) begin
                if (c1_rr[c] && c1_rv[c]) begin
                    order.push_back(c);
                    chk("one_rdata", {24'd0, c1_rdata[c]},
                        {24'd0, c1_ra[c] ^ 8'h5A});
                    c1_rv[c] = 1'b0;
                end
            end
        end
        chk("one_count", order.size(), 3);
        for (int i = 0; i < order.size(); i++) chk("one_order", order[i], i);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 37 + 5);
            ref_mem[i] = 8'(i * 37 + 5);
        end
        @(negedge clk);
        rand_mode = 1'b1;
        fork
            cons_proc(0);
            cons_proc(1);
            cons_proc(2);
            cons_proc(3);
        join
        repeat (3) @(negedge clk);
        rand_mode = 1'b0;
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("rnd_mem_final", nbad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Arbitrates load/store requests from NUM_CONSUMERS per-thread load-store units onto NUM_CHANNELS data-memory channels.
- Sits directly downstream of the per-thread LSUs and upstream of external data memory.
- Uses a valid/ready handshake on both sides. Each channel serves one consumer transaction at a time; a consumer is never served by two channels at once.

Parameters:
ADDR_BITS, 8, data memory address width
DATA_BITS, 8, data memory word width
NUM_CONSUMERS, 4, number of LSUs attached
NUM_CHANNELS, 2, number of concurrent memory channels (1..NUM_CONSUMERS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
consumer_read_valid  in  [NUM_CONSUMERS]  per-LSU read request, held until ready seen
consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address
consumer_read_ready  out  [NUM_CONSUMERS]  read data valid / request complete
consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned read data
consumer_write_valid  in  [NUM_CONSUMERS]  per-LSU write request
consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address
consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data
consumer_write_ready  out  [NUM_CONSUMERS]  write complete
mem_read_valid  out  [NUM_CHANNELS]  read request to memory
mem_read_address  out  [NUM_CHANNELS][ADDR_BITS]  memory read address
mem_read_ready  in  [NUM_CHANNELS]  memory read data valid
mem_read_data  in  [NUM_CHANNELS][DATA_BITS]  memory read data
mem_write_valid  out  [NUM_CHANNELS]  write request to memory
mem_write_address  out  [NUM_CHANNELS][ADDR_BITS]  memory write address
mem_write_data  out  [NUM_CHANNELS][DATA_BITS]  memory write data
mem_write_ready  in  [NUM_CHANNELS]  memory write accepted

Behaviour:
- Reset (reset==0, async):
  - All outputs 0.
  - All channels IDLE; claimed-consumer mask cleared; per-channel consumer index 0.
  - In-flight memory transactions are abandoned, with no completion to consumers.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Scan consumers from index 0 upward; pick the first one with read_valid or write_valid that is not in the claimed mask.
  - If both read and write are valid on the same consumer, read wins.
  - On pick, next cycle:
    - Set the claimed bit and record the consumer index.
    - For a read: latch the address onto mem_read_address, set mem_read_valid=1, go to READ_WAIT.
    - For a write: latch address and data onto mem_write_*, set mem_write_valid=1, go to WRITE_WAIT.
- Simultaneous claim:
  - Channels are evaluated in ascending channel index within one cycle, against a running mask.
  - Channel 0 takes the lowest free consumer, channel 1 the next, and so on. No consumer is ever claimed twice.
- READ_WAIT: hold mem_read_valid/address. On mem_read_ready=1, next cycle: mem_read_valid=0, consumer_read_data[c]=mem_read_data, consumer_read_ready[c]=1, go to RELAY.
- WRITE_WAIT: hold mem_write_*. On mem_write_ready=1, next cycle: mem_write_valid=0, consumer_write_ready[c]=1, go to RELAY.
- RELAY:
  - Hold ready (and read data) until the consumer deasserts the corresponding valid.
  - Then, next cycle: ready=0, claimed bit cleared, go to IDLE.
  - The channel may claim again from IDLE on the following cycle.
- Latency (read, zero-wait memory):
  - valid seen at cycle t; mem_read_valid at t+1.
  - If mem_read_ready at t+1, consumer_read_ready at t+2.
  - Consumer drops valid at t+3; ready low and channel IDLE at t+4.
- Fixed priority; starvation of high-index consumers under continuous load is accepted.
- Memory ready asserted while the channel is not in a WAIT state is ignored.
- Consumer valid dropping before ready is a protocol violation; behaviour is undefined and it is not checked.
- consumer_read_data[c] keeps its last value after ready falls.

Decomposition:
- Package mem_ctrl_pkg: mem_ctrl_state_t enum {IDLE, READ_WAIT, WRITE_WAIT, RELAY} (2-bit).
- Arbitration and claimed mask stay in the parent, since they are shared across channels.
- Per-channel datapath registers and FSM are generated in a loop. No separate sub-module: claim logic is cross-channel.

Test Plan:
- Consumer 1 read addr 0x12, memory returns 0xA5 with ready 1 cycle after valid -> mem_read_address[0]=0x12; consumer_read_data[1]=0xA5 with ready at t+2; channel 0 IDLE after consumer drops valid.
- Consumer 2 write addr 0x40 data 0x3C, mem_write_ready delayed 3 cycles -> mem_write_valid held 3 cycles with 0x40/0x3C; consumer_write_ready[2] asserted the cycle after mem ready.
- Consumers 0 and 3 read simultaneously, 2 channels -> channel 0 serves consumer 0, channel 1 serves consumer 3, same cycle; both complete independently.
- NUM_CHANNELS=1, consumers 0,1,2 read together -> served strictly in order 0,1,2; no overlap of mem_read_valid transactions.
- Consumer 0 asserts both read and write -> read issued first; write issued after read relay completes and the channel returns to IDLE.
- Reset asserted during READ_WAIT -> all outputs 0 immediately; after release, a new request from the same consumer completes normally.
